// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_pkg                                                    |
// | Brief   : ALU function-code encoding, opcode/funct values and the    |
// |           decoded control bundle shared by decoder and datapath.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package alu_pkg;

  // alufn[4:3] unit select
  localparam logic [1:0] UNIT_ADD   = 2'b00;
  localparam logic [1:0] UNIT_SHIFT = 2'b01;
  localparam logic [1:0] UNIT_LOGIC = 2'b10;
  localparam logic [1:0] UNIT_CMP   = 2'b11;

  // alufn[1:0] boolean op, consumed directly by the logical unit
  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // alufn[1:0] shift op
  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b10;
  localparam logic [1:0] OP_SRA = 2'b11;

  // alufn[1:0] compare op: bit 0 selects unsigned
  localparam logic [1:0] OP_CMP_S = 2'b00;
  localparam logic [1:0] OP_CMP_U = 2'b01;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  // R-type funct codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef struct packed {
    logic [4:0] alufn;
    logic       use_imm;
    logic       imm_zext;
    logic       lui;
    logic       illegal;
  } dec_bundle_t;

  // Build a legal decode result from its fields.
  function automatic dec_bundle_t mk_dec(
    input logic [1:0] unit,
    input logic       sub,
    input logic [1:0] op,
    input logic       use_imm,
    input logic       imm_zext,
    input logic       lui
  );
    dec_bundle_t b;
    b.alufn    = {unit, sub, op};
    b.use_imm  = use_imm;
    b.imm_zext = imm_zext;
    b.lui      = lui;
    b.illegal  = 1'b0;
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_dec_comb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_dec_comb                                               |
// | Brief   : Purely combinational instruction -> ALU control decode.    |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_dec_comb
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output dec_bundle_t dec
);

  logic [5:0] w_opcode;
  logic [5:0] w_funct;

  assign w_opcode = instr[31:26];
  assign w_funct  = instr[5:0];

  // Table decode; anything not matched falls through to the all-zero illegal bundle.
  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    case (w_opcode)
      OPC_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADDU: dec = mk_dec(UNIT_ADD,   1'b0, OP_AND,   1'b0, 1'b0, 1'b0);
          FN_SUB, FN_SUBU: dec = mk_dec(UNIT_ADD,   1'b1, OP_AND,   1'b0, 1'b0, 1'b0);
          FN_AND:          dec = mk_dec(UNIT_LOGIC, 1'b0, OP_AND,   1'b0, 1'b0, 1'b0);
          FN_OR:           dec = mk_dec(UNIT_LOGIC, 1'b0, OP_OR,    1'b0, 1'b0, 1'b0);
          FN_XOR:          dec = mk_dec(UNIT_LOGIC, 1'b0, OP_XOR,   1'b0, 1'b0, 1'b0);
          FN_NOR:          dec = mk_dec(UNIT_LOGIC, 1'b0, OP_NOR,   1'b0, 1'b0, 1'b0);
          FN_SLT:          dec = mk_dec(UNIT_CMP,   1'b1, OP_CMP_S, 1'b0, 1'b0, 1'b0);
          FN_SLTU:         dec = mk_dec(UNIT_CMP,   1'b1, OP_CMP_U, 1'b0, 1'b0, 1'b0);
          FN_SLL:          dec = mk_dec(UNIT_SHIFT, 1'b0, OP_SLL,   1'b0, 1'b0, 1'b0);
          FN_SRL:          dec = mk_dec(UNIT_SHIFT, 1'b0, OP_SRL,   1'b0, 1'b0, 1'b0);
          FN_SRA:          dec = mk_dec(UNIT_SHIFT, 1'b0, OP_SRA,   1'b0, 1'b0, 1'b0);
          default: ;
        endcase
      end
      OPC_ADDI, OPC_ADDIU: dec = mk_dec(UNIT_ADD,   1'b0, OP_AND,   1'b1, 1'b0, 1'b0);
      OPC_SLTI:            dec = mk_dec(UNIT_CMP,   1'b1, OP_CMP_S, 1'b1, 1'b0, 1'b0);
      OPC_SLTIU:           dec = mk_dec(UNIT_CMP,   1'b1, OP_CMP_U, 1'b1, 1'b0, 1'b0);
      OPC_ANDI:            dec = mk_dec(UNIT_LOGIC, 1'b0, OP_AND,   1'b1, 1'b1, 1'b0);
      OPC_ORI:             dec = mk_dec(UNIT_LOGIC, 1'b0, OP_OR,    1'b1, 1'b1, 1'b0);
      OPC_XORI:            dec = mk_dec(UNIT_LOGIC, 1'b0, OP_XOR,   1'b1, 1'b1, 1'b0);
      OPC_LUI:             dec = mk_dec(UNIT_SHIFT, 1'b0, OP_SLL,   1'b1, 1'b1, 1'b1);
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : alu_ctrl_decoder                                           |
// | Brief   : Registered instruction -> ALU control decoder with a       |
// |           2-entry skid buffer and saturating illegal counter.        |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module alu_ctrl_decoder
  import alu_pkg::*;
#(
  parameter int ILLCNT_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4:0]          alufn,
  output logic                use_imm,
  output logic                imm_zext,
  output logic                lui,
  output logic                illegal,
  output logic [ILLCNT_W-1:0] illegal_count
);

  dec_bundle_t         w_dec;
  logic                w_accept;
  logic                w_main_free;

  dec_bundle_t         main_q,      main_d;
  logic                main_vld_q,  main_vld_d;
  dec_bundle_t         skid_q,      skid_d;
  logic                skid_vld_q,  skid_vld_d;
  logic [ILLCNT_W-1:0] cnt_q,       cnt_d;

  alu_dec_comb u_dec (
    .instr (instr),
    .dec   (w_dec)
  );

  // in_ready comes straight from a flop, so upstream never sees a combinational path.
  assign in_ready    = !skid_vld_q;
  assign w_accept    = in_valid && in_ready;
  assign w_main_free = !main_vld_q || out_ready;

  // Skid buffer steering and illegal-count update.
  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;

    if (w_main_free) begin
      if (skid_vld_q) begin
        // Older beat in skid goes first; no accept is possible while skid is full.
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (w_accept) begin
        main_d     = w_dec;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (w_accept) begin
      skid_d     = w_dec;
      skid_vld_d = 1'b1;
    end

    if (w_accept && w_dec.illegal && (cnt_q != {ILLCNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // State registers; reset drops any beat offered in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q     <= '0;
      main_vld_q <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      main_vld_q <= main_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid     = main_vld_q;
  assign alufn         = main_q.alufn;
  assign use_imm       = main_q.use_imm;
  assign imm_zext      = main_q.imm_zext;
  assign lui           = main_q.lui;
  assign illegal       = main_q.illegal;
  assign illegal_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_alu_ctrl_decoder                                        |
// | Brief   : Directed self-checking bench for alu_ctrl_decoder.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_alu_ctrl_decoder;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  alufn;
  logic        use_imm;
  logic        imm_zext;
  logic        lui;
  logic        illegal;
  logic [7:0]  illegal_count;

  int          n_checks;
  int          n_errs;
  logic [7:0]  exp_cnt;

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [4:0]  alufn;
    logic        use_imm;
    logic        imm_zext;
    logic        lui;
    logic        illegal;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vecs [NVEC];
  vec_t v_and, v_nor, v_ori, v_bad;

  alu_ctrl_decoder #(.ILLCNT_W(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .instr         (instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .alufn         (alufn),
    .use_imm       (use_imm),
    .imm_zext      (imm_zext),
    .lui           (lui),
    .illegal       (illegal),
    .illegal_count (illegal_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input vec_t v);
    chk({v.name, " out_valid"}, {31'b0, out_valid}, 32'd1);
    chk({v.name, " alufn"},     {27'b0, alufn},     {27'b0, v.alufn});
    chk({v.name, " use_imm"},   {31'b0, use_imm},   {31'b0, v.use_imm});
    chk({v.name, " imm_zext"},  {31'b0, imm_zext},  {31'b0, v.imm_zext});
    chk({v.name, " lui"},       {31'b0, lui},       {31'b0, v.lui});
    chk({v.name, " illegal"},   {31'b0, illegal},   {31'b0, v.illegal});
    chk({v.name, " count"},     {24'b0, illegal_count}, {24'b0, exp_cnt});
  endtask

  // One isolated beat with out_ready=1: visible 1 cycle after accept, gone the next.
  task automatic send_check(input vec_t v);
    @(negedge clk);
    in_valid = 1'b1;
    instr    = v.instr;
    chk({v.name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    if (v.illegal && exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
    chk_out(v);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk({v.name, " drained"}, {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    exp_cnt  = 8'd0;

    vecs[0]  = '{"illegal_op", 32'hFC000000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1]  = '{"and",        32'h00851024, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{"nor",        32'h00851027, 5'b10011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{"ori",        32'h34420001, 5'b10001, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[4]  = '{"lui",        32'h3C011234, 5'b01000, 1'b1, 1'b1, 1'b1, 1'b0};
    vecs[5]  = '{"slti",       32'h2821FFFF, 5'b11100, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{"add",        32'h00851020, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{"addu",       32'h00851021, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{"sub",        32'h00851022, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{"subu",       32'h00851023, 5'b00100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{"or",         32'h00851025, 5'b10001, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{"xor",        32'h00851026, 5'b10010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{"slt",        32'h0085102A, 5'b11100, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{"sltu",       32'h0085102B, 5'b11101, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{"sll",        32'h00041080, 5'b01000, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{"srl",        32'h00041082, 5'b01010, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[16] = '{"sra",        32'h00041083, 5'b01011, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[17] = '{"addi",       32'h2021FFFF, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[18] = '{"addiu",      32'h2421FFFF, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[19] = '{"sltiu",      32'h2C210001, 5'b11101, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[20] = '{"andi",       32'h30420001, 5'b10000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[21] = '{"xori",       32'h38420001, 5'b10010, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[22] = '{"bad_funct",  32'h00851028, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[23] = '{"bad_opc",    32'h10000000, 5'b00000, 1'b0, 1'b0, 1'b0, 1'b1};
    v_bad = vecs[0];
    v_and = vecs[1];
    v_nor = vecs[2];
    v_ori = vecs[3];

    // Reset state
    reset     = 1'b1;
    in_valid  = 1'b0;
    instr     = 32'h0;
    out_ready = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst alufn",     {27'b0, alufn},     32'd0);
    chk("rst flags",     {28'b0, use_imm, imm_zext, lui, illegal}, 32'd0);
    chk("rst count",     {24'b0, illegal_count}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Decode table, one isolated beat per entry
    for (int i = 0; i < NVEC; i++) begin
      send_check(vecs[i]);
    end

    // Back-to-back with simultaneous drain and accept
    @(negedge clk);
    in_valid = 1'b1;
    instr    = v_and.instr;
    @(posedge clk);
    #1;
    chk_out(v_and);
    @(negedge clk);
    instr = v_nor.instr;
    @(posedge clk);
    #1;
    chk_out(v_nor);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("b2b drained", {31'b0, out_valid}, 32'd0);

    // Backpressure: stall with three beats offered
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = v_and.instr;
    @(posedge clk);
    #1;
    chk_out(v_and);
    chk("bp in_ready 1", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    instr = v_nor.instr;
    @(posedge clk);
    #1;
    chk("bp in_ready 2", {31'b0, in_ready}, 32'd0);
    chk_out(v_and);
    @(negedge clk);
    instr = v_ori.instr;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("bp stall in_ready", {31'b0, in_ready}, 32'd0);
      chk_out(v_and);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_out(v_nor);
    chk("bp skid freed", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    chk_out(v_ori);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("bp drained", {31'b0, out_valid}, 32'd0);

    // Saturation of the illegal counter
    @(negedge clk);
    in_valid = 1'b1;
    instr    = v_bad.instr;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      if (k == 100) chk("sat mid count", {24'b0, illegal_count}, {24'b0, exp_cnt});
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("sat count model", {24'b0, illegal_count}, {24'b0, exp_cnt});
    chk("sat count 255",   {24'b0, illegal_count}, 32'd255);

    // Reset with both entries full and a beat offered in the reset cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    instr     = v_nor.instr;
    @(posedge clk);
    @(negedge clk);
    instr = v_bad.instr;
    @(posedge clk);
    #1;
    chk("full in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    instr = v_and.instr;
    @(posedge clk);
    #1;
    chk("mid rst out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid rst in_ready",  {31'b0, in_ready},  32'd1);
    chk("mid rst count",     {24'b0, illegal_count}, 32'd0);
    chk("mid rst alufn",     {27'b0, alufn},     32'd0);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    exp_cnt   = 8'd0;
    @(posedge clk);
    #1;
    chk("post rst idle", {31'b0, out_valid}, 32'd0);
    send_check(v_ori);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_ctrl_decoder.md
Name: alu_ctrl_decoder

Overview:
Registered instruction-to-ALU-control decoder. It sits between fetch/issue and the datapath ALU, and is the producer side of the ALU function code. It converts a 32-bit MIPS-style instruction into the 5-bit ALU function code, including the 2-bit boolean op consumed by the logical unit, plus immediate-handling controls. Valid/ready handshake on both sides, with a 2-entry skid buffer so upstream sees a registered ready.

Parameters:
ILLCNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  instruction offered.
in_ready  output  1  decoder can accept; depends only on registered state.
instr  input  32  instruction word, sampled when in_valid && in_ready.
out_valid  output  1  decoded bundle available.
out_ready  input  1  consumer accepts.
alufn  output  5  ALU function code.
- [4:3] unit: 00 add/sub, 01 shift, 10 logical, 11 compare.
- [2] subtract.
- [1:0] op: logical 00 AND / 01 OR / 10 XOR / 11 NOR; shift 00 SLL / 10 SRL / 11 SRA; compare [0]=unsigned.
use_imm  output  1  operand B is the immediate.
imm_zext  output  1  immediate is zero-extended (else sign-extended).
lui  output  1  load-upper: immediate shifted left 16.
illegal  output  1  instruction not in decode table.
illegal_count  output  ILLCNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Reset (synchronous): out_valid=0, in_ready=1, alufn=0, use_imm=0, imm_zext=0, lui=0, illegal=0, illegal_count=0, both buffer entries empty. Reset wins over any simultaneous transfer, so a beat offered in the reset cycle is dropped.
- Accept: transfer occurs when in_valid && in_ready at a clock edge. Decode is combinational on instr; the result is registered.
- Latency: exactly 1 cycle from accept to out_valid when the output stage is empty or draining in the same cycle.
- Storage: the main register drives the outputs, and the skid register holds a second entry.
- in_ready = !skid_full.
- If an accept occurs while main is full and not draining, the new beat goes to skid.
- When main drains, skid moves to main if it is full; otherwise the incoming beat loads main.
- Ordering is strictly FIFO.
- While out_valid && !out_ready, all output fields hold stable.
- Simultaneous drain and accept with skid empty: main reloads with the new beat and out_valid stays 1.
- Decode table, opcode = instr[31:26], funct = instr[5:0]:
  - opcode 0x00, R-type:
    - funct 0x20/0x21 add → 00_0_00.
    - 0x22/0x23 sub → 00_1_00.
    - 0x24 and → 10_0_00.
    - 0x25 or → 10_0_01.
    - 0x26 xor → 10_0_10.
    - 0x27 nor → 10_0_11.
    - 0x2A slt → 11_1_00.
    - 0x2B sltu → 11_1_01.
    - 0x00 sll → 01_0_00.
    - 0x02 srl → 01_0_10.
    - 0x03 sra → 01_0_11.
    - use_imm=0 for all R-type.
  - I-type, all with use_imm=1:
    - 0x08/0x09 addi/addiu → 00_0_00, sign-extended.
    - 0x0A slti → 11_1_00, sign-extended.
    - 0x0B sltiu → 11_1_01, sign-extended.
    - 0x0C andi → 10_0_00, zero-extended.
    - 0x0D ori → 10_0_01, zero-extended.
    - 0x0E xori → 10_0_10, zero-extended.
    - 0x0F lui → 01_0_00 with lui=1, zero-extended.
  - Anything else, including an unknown R-type funct: illegal=1, alufn=0, use_imm=0, imm_zext=0, lui=0.
- illegal_count increments by 1 at accept of an illegal beat and saturates at all-ones with no wrap. It counts at accept, not at output.

Decomposition:
- Package alu_pkg holds:
  - Unit-select constants UNIT_ADD/SHIFT/LOGIC/CMP.
  - Boolean-op constants OP_AND/OR/XOR/NOR, shared with the logical unit.
  - Opcode and funct localparams.
  - Packed struct dec_bundle_t {alufn, use_imm, imm_zext, lui, illegal}.
- One sub-module, alu_dec_comb: purely combinational instr → dec_bundle_t. The top module holds the skid buffer and the counter.

Test Plan:
- Decode the logical set with out_ready=1:
  - 0x00851024 (and) → alufn=10000.
  - 0x00851027 (nor) → alufn=10011.
  - 0x34420001 (ori) → alufn=10001, use_imm=1, imm_zext=1.
  - Each appears exactly 1 cycle after its accept.
- 0x3C011234 (lui) → alufn=01000, lui=1, use_imm=1, imm_zext=1. 0x2821FFFF (slti) → alufn=11100, imm_zext=0.
- Backpressure: hold out_ready=0 and stream 3 beats → the first two are accepted and in_ready=0 on the third. Release out_ready → the beats emerge in order with no loss or duplication, and outputs stay stable while stalled.
- Illegal: instr=0xFC000000 → illegal=1, alufn=0, illegal_count 0→1. Force 300 illegal beats with ILLCNT_W=8 → count saturates at 255.
- Reset mid-operation: both buffer entries full, then assert reset for 1 cycle → next cycle out_valid=0, in_ready=1, illegal_count=0; a subsequent beat decodes normally.
